preset_writer: RTL and testbench

Writer end of the digit-counter preset interface. It takes a multi-digit BCD time value through a valid/ready handshake and validates every digit. It then drives the counters' per-bit clear and set lines in a fixed clear-then-set pulse sequence, holding the counters frozen while it does so. Finally it reads the counter outputs back and reports done or error. It sits between the irrigation-time setup logic and the minute/second digit counters.

---
 rtl/preset_writer.sv | 152 +++++++++++++++
 tb/tb_preset_writer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/preset_writer.sv
// Writer end of the digit-counter preset interface.
// Accepts a BCD value over valid/ready and rejects it if any digit is above 9. A valid
// value is written to the counters with a clear pulse, a one-cycle gap and a set pulse,
// while hold keeps them frozen. The counter outputs are then compared against the value
// until they match or the verify window runs out.
module preset_writer #(
  parameter int unsigned DIGITS         = 2,
  parameter int unsigned PULSE_CYCLES   = 2,
  parameter int unsigned VERIFY_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic                  hold,
  output logic [4*DIGITS-1:0]   clear_o,
  output logic [4*DIGITS-1:0]   set_o,
  input  logic [4*DIGITS-1:0]   readback,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam int unsigned W = 4 * DIGITS;
  // Terminal counts: the counter starts at 0 on phase entry, so a phase of N cycles
  // ends when the count reaches N-1.
  localparam logic [7:0] PulseLast  = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] VerifyLast = 8'(VERIFY_TIMEOUT - 1);

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrBadBcd  = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StClear,
    StGap,
    StSet,
    StVerify,
    StDone,
    StErr
  } state_e;

  state_e         state;
  logic [W-1:0]   value;
  logic [7:0]     cnt;
  logic           bad_digit;

  // Flag any captured nibble outside the BCD range 0..9.
  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (value[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Sequencer with every output registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      value      <= '0;
      cnt        <= '0;
      load_ready <= 1'b1;
      hold       <= 1'b0;
      clear_o    <= '0;
      set_o      <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ErrNone;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        StIdle: begin
          if (load_valid && load_ready) begin
            value      <= load_value;
            err_code   <= ErrNone;
            load_ready <= 1'b0;
            state      <= StCheck;
          end
        end
        StCheck: begin
          if (bad_digit) begin
            error    <= 1'b1;
            err_code <= ErrBadBcd;
            state    <= StErr;
          end else begin
            hold    <= 1'b1;
            clear_o <= '1;
            cnt     <= '0;
            state   <= StClear;
          end
        end
        StClear: begin
          if (cnt == PulseLast) begin
            clear_o <= '0;
            state   <= StGap;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StGap: begin
          // The gap cycle keeps clear and set from ever overlapping.
          set_o <= value;
          cnt   <= '0;
          state <= StSet;
        end
        StSet: begin
          if (cnt == PulseLast) begin
            set_o <= '0;
            cnt   <= '0;
            state <= StVerify;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StVerify: begin
          // A match on the last allowed cycle still counts as success.
          if (readback == value) begin
            hold  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end else if (cnt == VerifyLast) begin
            hold     <= 1'b0;
            error    <= 1'b1;
            err_code <= ErrTimeout;
            state    <= StErr;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StDone, StErr: begin
          cnt        <= '0;
          load_ready <= 1'b1;
          state      <= StIdle;
        end
        default: begin
          state      <= StIdle;
          load_ready <= 1'b1;
          hold       <= 1'b0;
          clear_o    <= '0;
          set_o      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_preset_writer.sv
// Bench for preset_writer: two instances (pulse width 2 and 1) checked every cycle
// against a timeline model derived from the accept-relative cycle numbering, plus
// literal expectations for the directed scenarios.
module tb_preset_writer;

  localparam int VT = 8;

  logic       clk;
  logic       rst  [2];
  logic       lv   [2];
  logic [7:0] lval [2];
  logic [7:0] rb   [2];
  logic       lr   [2];
  logic       hd   [2];
  logic       dn   [2];
  logic       er   [2];
  logic [7:0] clr  [2];
  logic [7:0] st   [2];
  logic [1:0] ec   [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Model state: k counts cycles since the accept edge (cycle 1 = first cycle after it).
  int         pc      [2] = '{2, 1};
  bit         busy    [2] = '{0, 0};
  int         k       [2] = '{0, 0};
  logic [7:0] mval    [2] = '{8'h00, 8'h00};
  bit         mbad    [2] = '{0, 0};
  int         endk    [2] = '{-1, -1};
  bit         enddone [2] = '{0, 0};
  logic [1:0] mec     [2] = '{2'b00, 2'b00};

  preset_writer #(.DIGITS(2), .PULSE_CYCLES(2), .VERIFY_TIMEOUT(VT)) u_dut0 (
    .clk(clk), .reset(rst[0]), .load_valid(lv[0]), .load_ready(lr[0]),
    .load_value(lval[0]), .hold(hd[0]), .clear_o(clr[0]), .set_o(st[0]),
    .readback(rb[0]), .done(dn[0]), .error(er[0]), .err_code(ec[0])
  );

  preset_writer #(.DIGITS(2), .PULSE_CYCLES(1), .VERIFY_TIMEOUT(VT)) u_dut1 (
    .clk(clk), .reset(rst[1]), .load_valid(lv[1]), .load_ready(lr[1]),
    .load_value(lval[1]), .hold(hd[1]), .clear_o(clr[1]), .set_o(st[1]),
    .readback(rb[1]), .done(dn[1]), .error(er[1]), .err_code(ec[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, from the phase windows relative to accept.
  task automatic model_check(input int i);
    logic       e_lr, e_hd, e_dn, e_er, endc;
    logic [7:0] e_clr, e_st;
    int         p;
    p = pc[i];
    if (!busy[i]) begin
      e_lr = 1; e_hd = 0; e_dn = 0; e_er = 0; e_clr = 0; e_st = 0;
    end else begin
      endc  = (k[i] == endk[i]);
      e_lr  = 0;
      e_dn  = endc && enddone[i];
      e_er  = endc && !enddone[i];
      e_clr = (!mbad[i] && k[i] >= 2 && k[i] <= 1 + p) ? 8'hFF : 8'h00;
      e_st  = (!mbad[i] && k[i] >= 3 + p && k[i] <= 2 + 2 * p) ? mval[i] : 8'h00;
      e_hd  = !mbad[i] && k[i] >= 2 && !endc;
    end
    pin($sformatf("dut%0d load_ready", i), 32'(lr[i]), 32'(e_lr));
    pin($sformatf("dut%0d hold", i), 32'(hd[i]), 32'(e_hd));
    pin($sformatf("dut%0d done", i), 32'(dn[i]), 32'(e_dn));
    pin($sformatf("dut%0d error", i), 32'(er[i]), 32'(e_er));
    pin($sformatf("dut%0d clear_o", i), 32'(clr[i]), 32'(e_clr));
    pin($sformatf("dut%0d set_o", i), 32'(st[i]), 32'(e_st));
    pin($sformatf("dut%0d err_code", i), 32'(ec[i]), 32'(mec[i]));
    pin($sformatf("dut%0d clr_and_set", i), 32'(clr[i] & st[i]), 32'd0);
    pin($sformatf("dut%0d done_and_error", i), 32'(dn[i] & er[i]), 32'd0);
  endtask

  // Advance the model across the coming edge using the inputs now applied.
  task automatic model_step(input int i);
    int p;
    p = pc[i];
    if (rst[i]) begin
      busy[i] = 0; mec[i] = 2'b00; endk[i] = -1; k[i] = 0;
    end else if (!busy[i]) begin
      if (lv[i]) begin
        busy[i] = 1; k[i] = 1; mval[i] = lval[i]; mec[i] = 2'b00; endk[i] = -1;
        mbad[i] = 0;
        for (int j = 0; j < 2; j++) begin
          if (((lval[i] >> (4 * j)) & 8'h0F) > 8'd9) mbad[i] = 1;
        end
      end
    end else if (k[i] == endk[i]) begin
      busy[i] = 0; k[i] = 0;
    end else begin
      if (mbad[i] && k[i] == 1) begin
        endk[i] = 2; enddone[i] = 0; mec[i] = 2'b01;
      end else if (!mbad[i] && k[i] >= 3 + 2 * p && k[i] <= 2 + 2 * p + VT) begin
        if (rb[i] == mval[i]) begin
          endk[i] = k[i] + 1; enddone[i] = 1;
        end else if (k[i] == 2 + 2 * p + VT) begin
          endk[i] = k[i] + 1; enddone[i] = 0; mec[i] = 2'b10;
        end
      end
      k[i]++;
    end
  endtask

  // One clock: check and advance the model mid-cycle, then land just after the edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) model_check(i);
    end
    for (int i = 0; i < 2; i++) model_step(i);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1; lv[i] = 0; lval[i] = 8'h00; rb[i] = 8'h00;
    end
    tick();
    tick();
    chk_en = 1;
    rst[0] = 0; rst[1] = 0;
    pin("reset load_ready", 32'(lr[0]), 32'd1);
    pin("reset clear_o", 32'(clr[0]), 32'd0);
    pin("reset err_code", 32'(ec[0]), 32'd0);

    // 0x37 with readback arriving at cycle 6.
    lval[0] = 8'h37; lv[0] = 1; tick(); lv[0] = 0;
    for (int c = 1; c <= 9; c++) begin
      if (c >= 6) rb[0] = 8'h37;
      if (c == 2) pin("t1 clear c2", 32'(clr[0]), 32'hFF);
      if (c == 3) pin("t1 clear c3", 32'(clr[0]), 32'hFF);
      if (c == 4) pin("t1 gap c4", 32'(clr[0] | st[0]), 32'h00);
      if (c == 5) pin("t1 set c5", 32'(st[0]), 32'h37);
      if (c == 6) pin("t1 set c6", 32'(st[0]), 32'h37);
      if (c == 7) pin("t1 hold c7", 32'(hd[0]), 32'd1);
      if (c == 7) pin("t1 done c7", 32'(dn[0]), 32'd0);
      if (c == 8) pin("t1 done c8", 32'(dn[0]), 32'd1);
      if (c == 8) pin("t1 hold c8", 32'(hd[0]), 32'd0);
      if (c == 8) pin("t1 err_code", 32'(ec[0]), 32'd0);
      tick();
    end

    // Reset during SET, then 0x12 completes.
    rb[0] = 8'h00; lval[0] = 8'h44; lv[0] = 1; tick(); lv[0] = 0;
    for (int c = 1; c <= 4; c++) tick();
    pin("t4 set before reset", 32'(st[0]), 32'h44);
    rst[0] = 1; tick(); rst[0] = 0;
    pin("t4 ready after reset", 32'(lr[0]), 32'd1);
    pin("t4 set after reset", 32'(st[0]), 32'd0);
    pin("t4 hold after reset", 32'(hd[0]), 32'd0);
    rb[0] = 8'h12; lval[0] = 8'h12; lv[0] = 1; tick(); lv[0] = 0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 8) pin("t4 done c8", 32'(dn[0]), 32'd1);
      tick();
    end

    // 0x3A is rejected in CHECK.
    lval[0] = 8'h3A; lv[0] = 1; tick(); lv[0] = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) pin("t2 error c2", 32'(er[0]), 32'd1);
      if (c == 2) pin("t2 err_code", 32'(ec[0]), 32'd1);
      if (c == 2) pin("t2 no pulses", 32'(clr[0] | st[0] | 8'(hd[0])), 32'd0);
      if (c == 3) pin("t2 ready c3", 32'(lr[0]), 32'd1);
      tick();
    end

    // 0x25 with readback stuck at 0 times out after 8 verify cycles.
    rb[0] = 8'h00; lval[0] = 8'h25; lv[0] = 1; tick(); lv[0] = 0;
    for (int c = 1; c <= 17; c++) begin
      if (c == 14) pin("t3 hold c14", 32'(hd[0]), 32'd1);
      if (c == 15) pin("t3 error c15", 32'(er[0]), 32'd1);
      if (c == 15) pin("t3 done c15", 32'(dn[0]), 32'd0);
      if (c == 15) pin("t3 err_code", 32'(ec[0]), 32'd2);
      if (c == 16) pin("t3 ready c16", 32'(lr[0]), 32'd1);
      tick();
    end

    // Back-to-back with load_valid held: 0x09 then 0x90.
    pin("t5 err_code before", 32'(ec[0]), 32'd2);
    rb[0] = 8'h09; lval[0] = 8'h09; lv[0] = 1; tick(); lval[0] = 8'h90;
    for (int c = 1; c <= 18; c++) begin
      if (c == 1) pin("t5 err_code cleared", 32'(ec[0]), 32'd0);
      if (c == 8) pin("t5 done1 c8", 32'(dn[0]), 32'd1);
      if (c == 9) pin("t5 ready c9", 32'(lr[0]), 32'd1);
      if (c == 10) pin("t5 second accept c10", 32'(lr[0]), 32'd0);
      if (c >= 10) rb[0] = 8'h90;
      if (c == 17) pin("t5 done2 c17", 32'(dn[0]), 32'd1);
      if (c == 18) lv[0] = 0;
      tick();
    end

    // Pulse width 1, value 0x00.
    rb[1] = 8'h00; lval[1] = 8'h00; lv[1] = 1; tick(); lv[1] = 0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 2) pin("t6 clear c2", 32'(clr[1]), 32'hFF);
      if (c == 3) pin("t6 gap c3", 32'(clr[1] | st[1]), 32'h00);
      if (c == 4) pin("t6 hold c4", 32'(hd[1]), 32'd1);
      if (c == 5) pin("t6 done c5", 32'(dn[1]), 32'd0);
      if (c == 6) pin("t6 done c6", 32'(dn[1]), 32'd1);
      tick();
    end

    // Randomized traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i] = ($urandom_range(0, 199) == 0);
        lv[i]  = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 3) != 0)
          lval[i] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        else
          lval[i] = 8'($urandom);
        rb[i] = ($urandom_range(0, 9) < 3) ? mval[i] : 8'($urandom);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
